// File: rtl/random.sv
// 16-bit Fibonacci LFSR pseudo-random nibble generator.
// Polynomial x^16+x^14+x^13+x^11+1 (maximal length, period 65535).
// Optional macro RANDOM_SEED_LOAD_EN adds a run-time seed load port pair.
module random #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
`ifdef RANDOM_SEED_LOAD_EN
    input  logic        seed_load,
    input  logic [15:0] seed_in,
`endif
    output logic [3:0]  data
);

    localparam int unsigned WIDTH = 16;
    localparam int unsigned DATA_W = 4;

    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] next_state;
    logic             fb;

    // Feedback taps and next-state selection (zero state recovers to SEED)
    always_comb begin
        fb         = state[15] ^ state[13] ^ state[12] ^ state[10];
        next_state = {state[WIDTH-2:0], fb};
        if (state == '0) begin
            next_state = SEED;
        end
`ifdef RANDOM_SEED_LOAD_EN
        if (seed_load) begin
            next_state = (seed_in == '0) ? SEED : seed_in;
        end
`endif
    end

    // State register; reset wins over load and stepping
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SEED;
        end else begin
            state <= next_state;
        end
    end

    // Output taken straight from the state register
    assign data = state[DATA_W-1:0];

endmodule

// File: tb/tb_random.sv
// Self-checking bench for random: scoreboard of expected states, data checked each edge.
// Define RANDOM_SEED_LOAD_EN to also exercise the seed-load ports.
module tb_random;

    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  data;
`ifdef RANDOM_SEED_LOAD_EN
    logic        seed_load;
    logic [15:0] seed_in;
`endif

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [15:0] m_state;
    logic [15:0] exp_q[$];

    random #(.SEED(SEED)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef RANDOM_SEED_LOAD_EN
        .seed_load (seed_load),
        .seed_in   (seed_in),
`endif
        .data      (data)
    );

    always #5 clk = ~clk;

    // Compare one observed value with its expectation
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference LFSR step: taps 16,14,13,11
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        logic f;
        f = s[15] ^ s[13] ^ s[12] ^ s[10];
        return {s[14:0], f};
    endfunction

    // Pop the expectation for this edge and compare data with it
    task automatic sample();
        logic [15:0] e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check("data", 32'(data), 32'(e[3:0]));
        end
    endtask

    // One edge with rst as given and no load
    task automatic step(input logic r);
        rst = r;
`ifdef RANDOM_SEED_LOAD_EN
        seed_load = 1'b0;
        seed_in   = 16'h0000;
`endif
        if (r) m_state = SEED;
        else if (m_state == 16'h0000) m_state = SEED;
        else m_state = lfsr_next(m_state);
        exp_q.push_back(m_state);
        sample();
    endtask

`ifdef RANDOM_SEED_LOAD_EN
    // One edge with seed_load high
    task automatic step_ld(input logic r, input logic [15:0] sin);
        rst       = r;
        seed_load = 1'b1;
        seed_in   = sin;
        if (r) m_state = SEED;
        else m_state = (sin == 16'h0000) ? SEED : sin;
        exp_q.push_back(m_state);
        sample();
        seed_load = 1'b0;
    endtask
`endif

    initial begin
        logic [15:0] tbl_state [4];
        logic [3:0]  tbl_data  [4];
        int unsigned hist [16];
        int unsigned first_rep;
        int unsigned zero_seen;

        tbl_state[0] = 16'hACE1; tbl_data[0] = 4'h1;
        tbl_state[1] = 16'h59C3; tbl_data[1] = 4'h3;
        tbl_state[2] = 16'hB387; tbl_data[2] = 4'h7;
        tbl_state[3] = 16'h670F; tbl_data[3] = 4'hF;

        rst = 1'b1;
`ifdef RANDOM_SEED_LOAD_EN
        seed_load = 1'b0;
        seed_in   = 16'h0000;
`endif
        m_state = 16'h0000;
        #2;

        // Reset held for two edges
        step(1'b1);
        step(1'b1);
        check("reset_state", 32'(dut.state), 32'(tbl_state[0]));
        check("reset_data", 32'(data), 32'(tbl_data[0]));

        // Known opening sequence
        for (int i = 1; i < 4; i++) begin
            step(1'b0);
            check("seq_state", 32'(dut.state), 32'(tbl_state[i]));
            check("seq_data", 32'(data), 32'(tbl_data[i]));
        end

        // Mid-run reset after 100 steps
        for (int i = 0; i < 100; i++) step(1'b0);
        step(1'b1);
        check("midrst_state", 32'(dut.state), 32'(16'hACE1));
        check("midrst_data", 32'(data), 32'd1);

        // Full period from SEED: data, distribution, no zero, first repeat
        for (int v = 0; v < 16; v++) hist[v] = 0;
        first_rep = 0;
        zero_seen = 0;
        for (int i = 1; i <= 65535; i++) begin
            step(1'b0);
            hist[data]++;
            if (dut.state == 16'h0000) zero_seen++;
            if (dut.state == SEED && first_rep == 0) first_rep = 32'(i);
        end
        check("period_first_repeat", first_rep, 32'd65535);
        check("period_zero_states", zero_seen, 32'd0);
        check("period_end_state", 32'(dut.state), 32'(16'hACE1));
        check("hist_0", hist[0], 32'd4095);
        for (int v = 1; v < 16; v++) begin
            check("hist_nz", hist[v], 32'd4096);
        end

        // Stepping continues after a full period
        step(1'b0);
        check("wrap_state", 32'(dut.state), 32'(16'h59C3));

`ifdef RANDOM_SEED_LOAD_EN
        // Seed load, zero seed fallback, reset priority over load
        step_ld(1'b0, 16'h1234);
        check("load_state", 32'(dut.state), 32'(16'h1234));
        check("load_data", 32'(data), 32'd4);
        step(1'b0);
        check("load_next", 32'(dut.state), 32'(lfsr_next(16'h1234)));
        step_ld(1'b0, 16'h0000);
        check("load_zero", 32'(dut.state), 32'(16'hACE1));
        step(1'b0);
        step_ld(1'b1, 16'h5555);
        check("rst_over_load", 32'(dut.state), 32'(16'hACE1));
`endif

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
